tl_master_buffer: RTL and testbench



---
 rtl/tl_master_buffer_if.sv | 85 ++++++++
 rtl/tl_master_buffer.sv | 168 ++++++++++++++++
 tb/tb_tl_master_buffer.sv | 312 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/tl_master_buffer_if.sv
// TileLink channel payload types and the five-channel bus interface used by tl_master_buffer.
// Payload field widths are fixed here; every buffer and the bus carry them unmodified.
package tl_pkg;
  typedef struct packed {
    logic [2:0]  opcode;
    logic [2:0]  param;
    logic [3:0]  size;
    logic [7:0]  source;
    logic [31:0] address;
    logic [3:0]  mask;
    logic [31:0] data;
    logic        corrupt;
  } A_chan_bits_t;

  typedef struct packed {
    logic [2:0]  opcode;
    logic [2:0]  param;
    logic [3:0]  size;
    logic [7:0]  source;
    logic [31:0] address;
    logic [3:0]  mask;
    logic [31:0] data;
    logic        corrupt;
  } B_chan_bits_t;

  typedef struct packed {
    logic [2:0]  opcode;
    logic [2:0]  param;
    logic [3:0]  size;
    logic [7:0]  source;
    logic [31:0] address;
    logic [31:0] data;
    logic        corrupt;
  } C_chan_bits_t;

  typedef struct packed {
    logic [2:0]  opcode;
    logic [1:0]  param;
    logic [3:0]  size;
    logic [7:0]  source;
    logic [7:0]  sink;
    logic        denied;
    logic [31:0] data;
    logic        corrupt;
  } D_chan_bits_t;

  typedef struct packed {
    logic [7:0] sink;
  } E_chan_bits_t;
endpackage

interface TL_BUS;
  logic                 a_valid;
  logic                 a_ready;
  tl_pkg::A_chan_bits_t a_bits;
  logic                 b_valid;
  logic                 b_ready;
  tl_pkg::B_chan_bits_t b_bits;
  logic                 c_valid;
  logic                 c_ready;
  tl_pkg::C_chan_bits_t c_bits;
  logic                 d_valid;
  logic                 d_ready;
  tl_pkg::D_chan_bits_t d_bits;
  logic                 e_valid;
  logic                 e_ready;
  tl_pkg::E_chan_bits_t e_bits;

  // Slave side of this connector drives the master-originated channels (A/C/E) onto the bus.
  modport Slave (
    output a_valid, a_bits, input a_ready,
    input  b_valid, b_bits, output b_ready,
    output c_valid, c_bits, input c_ready,
    input  d_valid, d_bits, output d_ready,
    output e_valid, e_bits, input e_ready
  );

  modport Master (
    input  a_valid, a_bits, output a_ready,
    output b_valid, b_bits, input b_ready,
    input  c_valid, c_bits, output c_ready,
    output d_valid, d_bits, input d_ready,
    input  e_valid, e_bits, output e_ready
  );
endinterface

// File: rtl/tl_master_buffer.sv
// Per-channel registered FIFOs between flat TileLink ports and a TL_BUS; 1-cycle latency (0 when DEPTH=0),
// ready depends only on occupancy. Optional stall counters under TL_MASTER_BUF_STALL_CNT_EN.
module tl_mb_fifo #(
  parameter int DEPTH = 2,
  parameter int W     = 8
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_wr_vld,
  output logic         o_wr_rdy,
  input  logic [W-1:0] i_wr_dat,
  output logic         o_rd_vld,
  input  logic         i_rd_rdy,
  output logic [W-1:0] o_rd_dat,
  output logic         o_empty
);
  if (DEPTH == 0) begin : g_pass
    logic w_unused_clk_rst;
    assign w_unused_clk_rst = i_clk ^ i_rst;
    assign o_wr_rdy = i_rd_rdy;
    assign o_rd_vld = i_wr_vld;
    assign o_rd_dat = i_wr_dat;
    assign o_empty  = 1'b1;
  end else begin : g_fifo
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [W-1:0]  r_mem [DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [CW-1:0] r_cnt;
    logic          w_push;
    logic          w_pop;

    // Ready looks only at the count, never at the downstream ready.
    assign o_wr_rdy = (r_cnt != FULL) && !i_rst;
    assign o_rd_vld = (r_cnt != '0);
    assign o_rd_dat = r_mem[r_rd_ptr];
    assign o_empty  = (r_cnt == '0);
    assign w_push   = i_wr_vld && o_wr_rdy;
    assign w_pop    = o_rd_vld && i_rd_rdy;

    always_ff @(posedge i_clk) begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= i_wr_dat;
      end
    end

    always_ff @(posedge i_clk) begin
      if (i_rst) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
        r_cnt    <= '0;
      end else begin
        if (w_push) begin
          r_wr_ptr <= (r_wr_ptr == LAST) ? '0 : r_wr_ptr + PW'(1);
        end
        if (w_pop) begin
          r_rd_ptr <= (r_rd_ptr == LAST) ? '0 : r_rd_ptr + PW'(1);
        end
        if (w_push && !w_pop) begin
          r_cnt <= r_cnt + CW'(1);
        end else if (!w_push && w_pop) begin
          r_cnt <= r_cnt - CW'(1);
        end
      end
    end
  end
endmodule

module tl_master_buffer #(
  parameter int A_DEPTH = 2,
  parameter int B_DEPTH = 2,
  parameter int C_DEPTH = 2,
  parameter int D_DEPTH = 2,
  parameter int E_DEPTH = 1
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 A_valid_i,
  output logic                 A_ready_o,
  input  tl_pkg::A_chan_bits_t A_bits_i,
  output logic                 B_valid_o,
  input  logic                 B_ready_i,
  output tl_pkg::B_chan_bits_t B_bits_o,
  input  logic                 C_valid_i,
  output logic                 C_ready_o,
  input  tl_pkg::C_chan_bits_t C_bits_i,
  output logic                 D_valid_o,
  input  logic                 D_ready_i,
  output tl_pkg::D_chan_bits_t D_bits_o,
  input  logic                 E_valid_i,
  output logic                 E_ready_o,
  input  tl_pkg::E_chan_bits_t E_bits_i,
  output logic                 idle_o,
  output logic [4:0][15:0]     stall_cnt_o,
  TL_BUS.Slave                 master
);
  logic [4:0] w_empty;

  tl_mb_fifo #(.DEPTH(A_DEPTH), .W($bits(tl_pkg::A_chan_bits_t))) u_a_fifo (
    .i_clk(clk_i), .i_rst(rst_i),
    .i_wr_vld(A_valid_i), .o_wr_rdy(A_ready_o), .i_wr_dat(A_bits_i),
    .o_rd_vld(master.a_valid), .i_rd_rdy(master.a_ready), .o_rd_dat(master.a_bits),
    .o_empty(w_empty[0])
  );

  tl_mb_fifo #(.DEPTH(B_DEPTH), .W($bits(tl_pkg::B_chan_bits_t))) u_b_fifo (
    .i_clk(clk_i), .i_rst(rst_i),
    .i_wr_vld(master.b_valid), .o_wr_rdy(master.b_ready), .i_wr_dat(master.b_bits),
    .o_rd_vld(B_valid_o), .i_rd_rdy(B_ready_i), .o_rd_dat(B_bits_o),
    .o_empty(w_empty[1])
  );

  tl_mb_fifo #(.DEPTH(C_DEPTH), .W($bits(tl_pkg::C_chan_bits_t))) u_c_fifo (
    .i_clk(clk_i), .i_rst(rst_i),
    .i_wr_vld(C_valid_i), .o_wr_rdy(C_ready_o), .i_wr_dat(C_bits_i),
    .o_rd_vld(master.c_valid), .i_rd_rdy(master.c_ready), .o_rd_dat(master.c_bits),
    .o_empty(w_empty[2])
  );

  tl_mb_fifo #(.DEPTH(D_DEPTH), .W($bits(tl_pkg::D_chan_bits_t))) u_d_fifo (
    .i_clk(clk_i), .i_rst(rst_i),
    .i_wr_vld(master.d_valid), .o_wr_rdy(master.d_ready), .i_wr_dat(master.d_bits),
    .o_rd_vld(D_valid_o), .i_rd_rdy(D_ready_i), .o_rd_dat(D_bits_o),
    .o_empty(w_empty[3])
  );

  tl_mb_fifo #(.DEPTH(E_DEPTH), .W($bits(tl_pkg::E_chan_bits_t))) u_e_fifo (
    .i_clk(clk_i), .i_rst(rst_i),
    .i_wr_vld(E_valid_i), .o_wr_rdy(E_ready_o), .i_wr_dat(E_bits_i),
    .o_rd_vld(master.e_valid), .i_rd_rdy(master.e_ready), .o_rd_dat(master.e_bits),
    .o_empty(w_empty[4])
  );

  // Pass-through channels report empty permanently, so they never hold idle low.
  assign idle_o = &w_empty;

`ifdef TL_MASTER_BUF_STALL_CNT_EN
  logic [4:0]       w_stall;
  logic [4:0][15:0] r_stall_cnt;

  // Stall is seen on each channel's upstream side: the master for A/C/E, the bus for B/D.
  assign w_stall = {E_valid_i & ~E_ready_o,
                    master.d_valid & ~master.d_ready,
                    C_valid_i & ~C_ready_o,
                    master.b_valid & ~master.b_ready,
                    A_valid_i & ~A_ready_o};

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_stall_cnt <= '0;
    end else begin
      for (int i = 0; i < 5; i++) begin
        if (w_stall[i] && (r_stall_cnt[i] != 16'hFFFF)) begin
          r_stall_cnt[i] <= r_stall_cnt[i] + 16'd1;
        end
      end
    end
  end

  assign stall_cnt_o = r_stall_cnt;
`else
  assign stall_cnt_o = '0;
`endif
endmodule

// File: tb/tb_tl_master_buffer.sv
// Bench for tl_master_buffer with A/C/D=2, B=0 (pass-through), E=1; queue scoreboard plus directed sequences.
module tb_tl_master_buffer;
  import tl_pkg::*;

  logic             clk_i = 1'b0;
  logic             rst_i;
  logic             A_valid_i;
  logic             A_ready_o;
  A_chan_bits_t     A_bits_i;
  logic             B_valid_o;
  logic             B_ready_i;
  B_chan_bits_t     B_bits_o;
  logic             C_valid_i;
  logic             C_ready_o;
  C_chan_bits_t     C_bits_i;
  logic             D_valid_o;
  logic             D_ready_i;
  D_chan_bits_t     D_bits_o;
  logic             E_valid_i;
  logic             E_ready_o;
  E_chan_bits_t     E_bits_i;
  logic             idle_o;
  logic [4:0][15:0] stall_cnt_o;

  TL_BUS bus ();

  tl_master_buffer #(
    .A_DEPTH(2), .B_DEPTH(0), .C_DEPTH(2), .D_DEPTH(2), .E_DEPTH(1)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .A_valid_i(A_valid_i), .A_ready_o(A_ready_o), .A_bits_i(A_bits_i),
    .B_valid_o(B_valid_o), .B_ready_i(B_ready_i), .B_bits_o(B_bits_o),
    .C_valid_i(C_valid_i), .C_ready_o(C_ready_o), .C_bits_i(C_bits_i),
    .D_valid_o(D_valid_o), .D_ready_i(D_ready_i), .D_bits_o(D_bits_o),
    .E_valid_i(E_valid_i), .E_ready_o(E_ready_o), .E_bits_i(E_bits_i),
    .idle_o(idle_o), .stall_cnt_o(stall_cnt_o),
    .master(bus)
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_errors = 0;

  A_chan_bits_t a_q[$];
  C_chan_bits_t c_q[$];
  D_chan_bits_t d_q[$];
  E_chan_bits_t e_q[$];

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk_i);
    #1;
  endtask

  function automatic A_chan_bits_t mk_a(input logic [7:0] d);
    A_chan_bits_t a;
    a         = '0;
    a.opcode  = 3'd4;
    a.source  = d;
    a.address = {24'h80_0000, d};
    a.mask    = 4'hF;
    a.data    = {4{d}};
    return a;
  endfunction

  function automatic C_chan_bits_t mk_c(input logic [7:0] d);
    C_chan_bits_t c;
    c         = '0;
    c.opcode  = 3'd6;
    c.source  = d;
    c.address = {24'h40_0000, d};
    c.data    = {4{d}};
    return c;
  endfunction

  function automatic D_chan_bits_t mk_d(input logic [7:0] d);
    D_chan_bits_t x;
    x        = '0;
    x.opcode = 3'd1;
    x.sink   = d;
    x.source = ~d;
    x.data   = {d, 8'h5A, d, 8'hA5};
    return x;
  endfunction

  // Scoreboard: beats enter on upstream handshakes and must leave, in order, on downstream handshakes.
  always @(negedge clk_i) begin
    if (rst_i === 1'b1) begin
      a_q.delete();
      c_q.delete();
      d_q.delete();
      e_q.delete();
    end else begin
      if (A_valid_i && A_ready_o) a_q.push_back(A_bits_i);
      if (C_valid_i && C_ready_o) c_q.push_back(C_bits_i);
      if (bus.d_valid && bus.d_ready) d_q.push_back(bus.d_bits);
      if (E_valid_i && E_ready_o) e_q.push_back(E_bits_i);
      if (bus.a_valid && bus.a_ready) begin
        if (a_q.size() == 0) chk("a_sb_unexpected", 1'b1, 1'b0);
        else chk("a_sb_data", bus.a_bits, a_q.pop_front());
      end
      if (bus.c_valid && bus.c_ready) begin
        if (c_q.size() == 0) chk("c_sb_unexpected", 1'b1, 1'b0);
        else chk("c_sb_data", bus.c_bits, c_q.pop_front());
      end
      if (D_valid_o && D_ready_i) begin
        if (d_q.size() == 0) chk("d_sb_unexpected", 1'b1, 1'b0);
        else chk("d_sb_data", D_bits_o, d_q.pop_front());
      end
      if (bus.e_valid && bus.e_ready) begin
        if (e_q.size() == 0) chk("e_sb_unexpected", 1'b1, 1'b0);
        else chk("e_sb_data", bus.e_bits, e_q.pop_front());
      end
    end
  end

  typedef struct {
    logic        rst;
    logic        vld;
    logic [31:0] dat;
    logic        rdy;
    logic        exp_vld;
    logic [31:0] exp_dat;
    logic        exp_bus_rdy;
    logic        exp_a_rdy;
  } bvec_t;

  bvec_t bt[6];

  initial begin
    // B pass-through vectors, including rows applied while reset is held.
    bt[0] = '{1'b0, 1'b1, 32'h0000_00B1, 1'b0, 1'b1, 32'h0000_00B1, 1'b0, 1'b1};
    bt[1] = '{1'b0, 1'b0, 32'h0000_00B2, 1'b1, 1'b0, 32'h0000_00B2, 1'b1, 1'b1};
    bt[2] = '{1'b1, 1'b1, 32'h0000_00B3, 1'b1, 1'b1, 32'h0000_00B3, 1'b1, 1'b0};
    bt[3] = '{1'b1, 1'b0, 32'h0000_00B4, 1'b0, 1'b0, 32'h0000_00B4, 1'b0, 1'b0};
    bt[4] = '{1'b0, 1'b1, 32'hCAFE_00B5, 1'b1, 1'b1, 32'hCAFE_00B5, 1'b1, 1'b1};
    bt[5] = '{1'b0, 1'b0, 32'h0000_0000, 1'b0, 1'b0, 32'h0000_0000, 1'b0, 1'b1};

    rst_i       = 1'b1;
    A_valid_i   = 1'b0;  A_bits_i = '0;
    B_ready_i   = 1'b0;
    C_valid_i   = 1'b0;  C_bits_i = '0;
    D_ready_i   = 1'b1;
    E_valid_i   = 1'b0;  E_bits_i = '0;
    bus.a_ready = 1'b0;
    bus.b_valid = 1'b0;  bus.b_bits = '0;
    bus.c_ready = 1'b0;
    bus.d_valid = 1'b0;  bus.d_bits = '0;
    bus.e_ready = 1'b0;

    cyc();
    cyc();
    @(negedge clk_i);
    chk("rst_a_ready", A_ready_o, 1'b0);
    chk("rst_c_ready", C_ready_o, 1'b0);
    chk("rst_e_ready", E_ready_o, 1'b0);
    chk("rst_a_valid", bus.a_valid, 1'b0);
    chk("rst_d_valid", D_valid_o, 1'b0);
    chk("rst_idle", idle_o, 1'b1);
    chk("rst_stall", stall_cnt_o, 80'h0);

    cyc();
    rst_i = 1'b0;
    @(negedge clk_i);
    chk("post_rst_a_ready", A_ready_o, 1'b1);
    chk("post_rst_d_ready", bus.d_ready, 1'b1);

    for (int i = 0; i < 6; i++) begin
      cyc();
      rst_i            = bt[i].rst;
      bus.b_valid      = bt[i].vld;
      bus.b_bits       = '0;
      bus.b_bits.data  = bt[i].dat;
      bus.b_bits.source = bt[i].dat[7:0];
      B_ready_i        = bt[i].rdy;
      @(negedge clk_i);
      chk($sformatf("b_valid[%0d]", i), B_valid_o, bt[i].exp_vld);
      chk($sformatf("b_data[%0d]", i), B_bits_o.data, bt[i].exp_dat);
      chk($sformatf("b_source[%0d]", i), B_bits_o.source, bt[i].exp_dat[7:0]);
      chk($sformatf("b_bus_ready[%0d]", i), bus.b_ready, bt[i].exp_bus_rdy);
      chk($sformatf("b_a_ready[%0d]", i), A_ready_o, bt[i].exp_a_rdy);
    end

    // A: two beats fill the FIFO while the bus stalls, then drain in order.
    cyc();
    A_valid_i = 1'b1;
    A_bits_i  = mk_a(8'h11);
    @(negedge clk_i);
    chk("a_ready_empty", A_ready_o, 1'b1);
    chk("a_no_bypass", bus.a_valid, 1'b0);
    cyc();
    A_bits_i = mk_a(8'h22);
    @(negedge clk_i);
    chk("a_lat1_valid", bus.a_valid, 1'b1);
    chk("a_lat1_bits", bus.a_bits, mk_a(8'h11));
    chk("a_ready_one", A_ready_o, 1'b1);
    cyc();
    A_valid_i = 1'b0;
    @(negedge clk_i);
    chk("a_ready_full", A_ready_o, 1'b0);
    chk("a_idle_busy", idle_o, 1'b0);
    chk("a_bits_stable", bus.a_bits, mk_a(8'h11));
    cyc();
    bus.a_ready = 1'b1;
    @(negedge clk_i);
    chk("a_drain0_valid", bus.a_valid, 1'b1);
    chk("a_drain0_bits", bus.a_bits, mk_a(8'h11));
    cyc();
    @(negedge clk_i);
    chk("a_drain1_valid", bus.a_valid, 1'b1);
    chk("a_drain1_bits", bus.a_bits, mk_a(8'h22));
    cyc();
    @(negedge clk_i);
    chk("a_drained_valid", bus.a_valid, 1'b0);
    chk("a_idle_back", idle_o, 1'b1);
    bus.a_ready = 1'b0;

    // D: continuous traffic through a 2-deep FIFO runs at full rate.
    for (int i = 0; i < 8; i++) begin
      cyc();
      bus.d_valid = (i < 6);
      bus.d_bits  = mk_d(8'hD0 + 8'(i));
      @(negedge clk_i);
      chk($sformatf("d_bus_ready[%0d]", i), bus.d_ready, 1'b1);
      chk($sformatf("d_valid[%0d]", i), D_valid_o, (i >= 1 && i <= 6));
      if (i >= 1 && i <= 6) chk($sformatf("d_bits[%0d]", i), D_bits_o, mk_d(8'hD0 + 8'(i - 1)));
    end
    bus.d_valid = 1'b0;

    // E: a single entry alternates between accepting and emitting.
    bus.e_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      cyc();
      E_valid_i     = 1'b1;
      E_bits_i.sink = 8'h40 + 8'(i);
      @(negedge clk_i);
      chk($sformatf("e_ready[%0d]", i), E_ready_o, (i % 2 == 0));
      chk($sformatf("e_valid[%0d]", i), bus.e_valid, (i % 2 == 1));
      if (i % 2 == 1) chk($sformatf("e_bits[%0d]", i), bus.e_bits.sink, 8'h40 + 8'(i - 1));
    end
    cyc();
    E_valid_i = 1'b0;
    bus.e_ready = 1'b0;

    // C: reset with two buffered beats discards them.
    C_valid_i = 1'b1;
    C_bits_i  = mk_c(8'hC1);
    @(negedge clk_i);
    chk("c_ready_empty", C_ready_o, 1'b1);
    cyc();
    C_bits_i = mk_c(8'hC2);
    @(negedge clk_i);
    chk("c_valid_one", bus.c_valid, 1'b1);
    cyc();
    C_bits_i = mk_c(8'hC3);
    rst_i    = 1'b1;
    @(negedge clk_i);
    chk("c_ready_full_rst", C_ready_o, 1'b0);
    chk("c_idle_before_rst", idle_o, 1'b0);
    cyc();
    @(negedge clk_i);
    chk("c_valid_after_rst", bus.c_valid, 1'b0);
    chk("c_idle_after_rst", idle_o, 1'b1);
    chk("c_ready_in_rst", C_ready_o, 1'b0);
    cyc();
    rst_i       = 1'b0;
    C_valid_i   = 1'b0;
    bus.c_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      chk($sformatf("c_no_stale[%0d]", i), bus.c_valid, 1'b0);
      cyc();
    end
    bus.c_ready = 1'b0;

    // Stall counting on a full A FIFO.
    rst_i = 1'b1;
    cyc();
    rst_i = 1'b0;
    for (int k = 0; k < 12; k++) begin
      cyc();
      A_valid_i = 1'b1;
      A_bits_i  = mk_a(8'hA0 + 8'(k));
    end
    @(negedge clk_i);
    chk("a_stall_ready", A_ready_o, 1'b0);
`ifdef TL_MASTER_BUF_STALL_CNT_EN
    chk("stall_cnt_short", stall_cnt_o, {64'h0, 16'd9});
    repeat (70000) cyc();
    @(negedge clk_i);
    chk("stall_cnt_sat", stall_cnt_o[0], 16'hFFFF);
    repeat (3) cyc();
    @(negedge clk_i);
    chk("stall_cnt_hold", stall_cnt_o[0], 16'hFFFF);
`else
    chk("stall_cnt_zero", stall_cnt_o, 80'h0);
`endif
    cyc();
    A_valid_i = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
